// File: rtl/fp_sp_pkg.sv
// Shared single-precision definitions for the FPU divider and multiplier.
// Simplified numeric model: denormals flush to zero, truncation rounding.
package fp_sp_pkg;

    localparam logic signed [9:0] EXP_BIAS = 10'sd127;
    localparam logic [7:0]        EXP_MAX  = 8'hFF;
    localparam int unsigned       MANT_W   = 24;
    localparam logic [31:0]       QNAN     = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp_sp_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

    // Exponent 0 is treated as zero regardless of fraction (denormal flush).
    function automatic fp_class_t fp_classify(input fp_sp_t x);
        if (x.exp == '0) begin
            return ZERO;
        end
        if (x.exp == EXP_MAX) begin
            return (x.frac != '0) ? NAN : INF;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/fp_sp_special_case.sv
// Special-operand resolution for single-precision division.
// Purely combinational; flags are {invalid, divByZero, overflow, underflow}.
module fp_sp_special_case
    import fp_sp_pkg::*;
#(
    parameter logic [31:0] NAN_PATTERN = QNAN
) (
    input  fp_class_t   cls_a,
    input  fp_class_t   cls_b,
    input  logic        sign,
    output logic        is_special,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    // Priority-ordered classification of the operand pair.
    always_comb begin
        is_special = 1'b1;
        result     = '0;
        flags      = '0;
        if (cls_a == NAN || cls_b == NAN) begin
            result = NAN_PATTERN;
            flags  = 4'b1000;
        end else if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
            result = NAN_PATTERN;
            flags  = 4'b1000;
        end else if (cls_a == NORMAL && cls_b == ZERO) begin
            result = {sign, EXP_MAX, 23'h0};
            flags  = 4'b0100;
        end else if (cls_a == INF) begin
            result = {sign, EXP_MAX, 23'h0};
        end else if (cls_a == ZERO || cls_b == INF) begin
            result = {sign, 31'h0};
        end else begin
            is_special = 1'b0;
        end
    end

endmodule

// File: rtl/fp_divider_sp_iterative.sv
// Sequential single-precision divider: restoring mantissa division,
// one quotient bit per clock, valid/ready handshake on both sides.
module fp_divider_sp_iterative
    import fp_sp_pkg::*;
#(
    parameter logic [31:0] NAN_PATTERN = QNAN
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic [31:0] i_Dividend,
    input  logic [31:0] i_Divisor,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_Quotient,
    output logic [3:0]  o_Flags
);

    localparam int unsigned ITERATIONS = MANT_W + 1;
    localparam logic [4:0]  LAST_ITER  = 5'(ITERATIONS - 1);

    // PACK is a single-clock stage shared by special and normal paths so
    // both paths register the result through the same output flops.
    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        PACK,
        DONE
    } state_t;

    state_t state_q, state_d;

    fp_sp_t    op_a, op_b;
    fp_class_t cls_a_in, cls_b_in;

    logic                sign_q;
    logic [7:0]          exp_a_q, exp_b_q;
    logic [MANT_W-1:0]   mant_b_q;
    logic [MANT_W+1:0]   rem_q;
    logic [MANT_W:0]     quo_q;
    logic [4:0]          cnt_q;
    fp_class_t           cls_a_q, cls_b_q;

    logic                rem_ge;
    logic [MANT_W+1:0]   rem_sub, rem_next;

    logic signed [9:0]   exp_norm;
    logic [MANT_W-2:0]   frac_norm;
    logic [31:0]         pack_result;
    logic [3:0]          pack_flags;

    logic                sc_special;
    logic [31:0]         sc_result;
    logic [3:0]          sc_flags;

    assign op_a     = i_Dividend;
    assign op_b     = i_Divisor;
    assign cls_a_in = fp_classify(op_a);
    assign cls_b_in = fp_classify(op_b);

    // State register.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d = state_q;
        o_Ready = 1'b0;
        o_Valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_Ready = 1'b1;
                if (i_Valid) begin
                    state_d = (cls_a_in == NORMAL && cls_b_in == NORMAL) ? DIVIDE : PACK;
                end
            end
            DIVIDE: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                state_d = DONE;
            end
            DONE: begin
                o_Valid = 1'b1;
                if (i_Ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One restoring-division step: subtract when possible, then shift.
    always_comb begin
        rem_ge   = rem_q >= {2'b00, mant_b_q};
        rem_sub  = rem_ge ? (rem_q - {2'b00, mant_b_q}) : rem_q;
        rem_next = rem_sub << 1;
    end

    // Normalise the raw quotient, apply range checks, merge special results.
    always_comb begin
        exp_norm  = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q})
                  + (quo_q[MANT_W] ? EXP_BIAS : (EXP_BIAS - 10'sd1));
        frac_norm = quo_q[MANT_W] ? quo_q[MANT_W-1:1] : quo_q[MANT_W-2:0];
        if (sc_special) begin
            pack_result = sc_result;
            pack_flags  = sc_flags;
        end else if (exp_norm >= 10'sd255) begin
            pack_result = {sign_q, EXP_MAX, 23'h0};
            pack_flags  = 4'b0010;
        end else if (exp_norm <= 10'sd0) begin
            pack_result = {sign_q, 31'h0};
            pack_flags  = 4'b0001;
        end else begin
            pack_result = {sign_q, exp_norm[7:0], frac_norm};
            pack_flags  = '0;
        end
    end

    fp_sp_special_case #(
        .NAN_PATTERN(NAN_PATTERN)
    ) u_special (
        .cls_a      (cls_a_q),
        .cls_b      (cls_b_q),
        .sign       (sign_q),
        .is_special (sc_special),
        .result     (sc_result),
        .flags      (sc_flags)
    );

    // Operand capture, iteration datapath and registered result.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            sign_q     <= 1'b0;
            exp_a_q    <= '0;
            exp_b_q    <= '0;
            mant_b_q   <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            cls_a_q    <= ZERO;
            cls_b_q    <= ZERO;
            o_Quotient <= '0;
            o_Flags    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Valid) begin
                        sign_q   <= op_a.sign ^ op_b.sign;
                        exp_a_q  <= op_a.exp;
                        exp_b_q  <= op_b.exp;
                        rem_q    <= {2'b01, op_a.frac};
                        mant_b_q <= {1'b1, op_b.frac};
                        quo_q    <= '0;
                        cnt_q    <= '0;
                        cls_a_q  <= cls_a_in;
                        cls_b_q  <= cls_b_in;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[MANT_W-1:0], rem_ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                PACK: begin
                    o_Quotient <= pack_result;
                    o_Flags    <= pack_flags;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_sp_iterative.sv
// Self-checking bench for fp_divider_sp_iterative.
module tb_fp_divider_sp_iterative;

    logic        i_CLK = 1'b0;
    logic        i_RSTn = 1'b1;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [31:0] i_Dividend = '0;
    logic [31:0] i_Divisor = '0;
    logic        o_Valid;
    logic        i_Ready = 1'b0;
    logic [31:0] o_Quotient;
    logic [3:0]  o_Flags;

    int n_tests = 0;
    int n_fail  = 0;

    fp_divider_sp_iterative #(
        .NAN_PATTERN(32'h7FC0_0000)
    ) dut (
        .i_CLK      (i_CLK),
        .i_RSTn     (i_RSTn),
        .i_Valid    (i_Valid),
        .o_Ready    (o_Ready),
        .i_Dividend (i_Dividend),
        .i_Divisor  (i_Divisor),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_Quotient (o_Quotient),
        .o_Flags    (o_Flags)
    );

    always #5 i_CLK = ~i_CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    // Reference: real-valued division semantics with the simplified model.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [3:0] f,
                                    output int lat);
        int ea, eb, e;
        bit za, zb, ia, ib, na, nb;
        logic s;
        longint unsigned ma, mb, ratio;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        s  = a[31] ^ b[31];
        f  = 4'b0000;
        lat = 1;
        if (na || nb) begin
            q = 32'h7FC0_0000; f = 4'b1000;
        end else if ((za && zb) || (ia && ib)) begin
            q = 32'h7FC0_0000; f = 4'b1000;
        end else if (zb && !ia) begin
            q = {s, 8'hFF, 23'h0}; f = 4'b0100;
        end else if (ia) begin
            q = {s, 8'hFF, 23'h0};
        end else if (za || ib) begin
            q = {s, 31'h0};
        end else begin
            lat = 26;
            ma = 64'h80_0000 | longint'(a[22:0]);
            mb = 64'h80_0000 | longint'(b[22:0]);
            ratio = (ma << 24) / mb;
            if (ratio >= 64'h100_0000) begin
                e = ea - eb + 127;
                ratio = ratio >> 1;
            end else begin
                e = ea - eb + 126;
            end
            if (e >= 255) begin
                q = {s, 8'hFF, 23'h0}; f = 4'b0010;
            end else if (e <= 0) begin
                q = {s, 31'h0}; f = 4'b0001;
            end else begin
                q = {s, 8'(e), 23'(ratio & 64'h7F_FFFF)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] fr;
        int unsigned sel;
        sel = $urandom_range(0, 15);
        fr  = 23'($urandom);
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       begin e = 8'hFF; fr = '0; end
            3:       e = 8'($urandom_range(1, 8));
            4:       e = 8'($urandom_range(247, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, fr};
    endfunction

    // Drive one operand pair, then wait (bounded) for o_Valid.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [3:0] f, output int lat);
        i_Dividend = a;
        i_Divisor  = b;
        i_Valid    = 1'b1;
        @(posedge i_CLK); #1;
        i_Valid = 1'b0;
        lat = 0;
        while (!o_Valid && lat < 200) begin
            @(posedge i_CLK); #1;
            lat++;
        end
        q = o_Quotient;
        f = o_Flags;
    endtask

    task automatic handshake();
        i_Ready = 1'b1;
        @(posedge i_CLK); #1;
        i_Ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 i_RSTn = 1'b0;
        @(posedge i_CLK); @(posedge i_CLK); #1;
        n_tests++;
        if ({o_Ready, o_Valid, o_Quotient, o_Flags} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h f=%h, expected rdy=1 vld=0 q=0 f=0",
                     o_Ready, o_Valid, o_Quotient, o_Flags);
        end
        i_RSTn = 1'b1;
        @(posedge i_CLK); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
                                32'hC000_0000, 32'h7F00_0000, 32'h0080_0000};
        logic [31:0] tb [7] = '{32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000,
                                32'h7F80_0000, 32'h3E80_0000, 32'h7F00_0000};
        logic [31:0] tq [7] = '{32'h4040_0000, 32'h3EAA_AAAA, 32'h7F80_0000, 32'h7FC0_0000,
                                32'h8000_0000, 32'h7F80_0000, 32'h0000_0000};
        logic [3:0]  tf [7] = '{4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h2, 4'h1};
        int          tl [7] = '{26, 26, 1, 1, 1, 26, 26};
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], q, f, lat);
            n_tests++;
            if (q !== tq[i] || f !== tf[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: %h / %h got q=%h f=%h, expected q=%h f=%h",
                         i, ta[i], tb[i], q, f, tq[i], tf[i]);
            end
            n_tests++;
            if (lat !== tl[i]) begin
                n_fail++;
                $display("FAIL directed_latency_%0d: got %0d, expected %0d", i, lat, tl[i]);
            end
            handshake();
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
        do_op(32'h3F80_0000, 32'h4040_0000, q, f, lat);
        for (int c = 0; c < 10; c++) begin
            i_Dividend = $urandom;
            i_Valid    = (c % 3 == 1);
            @(posedge i_CLK); #1;
            n_tests++;
            if ({o_Valid, o_Ready, o_Quotient, o_Flags} !== {1'b1, 1'b0, 32'h3EAA_AAAA, 4'h0}) begin
                n_fail++;
                $display("FAIL back_pressure_hold_%0d: got vld=%b rdy=%b q=%h f=%h, expected vld=1 rdy=0 q=3eaaaaaa f=0",
                         c, o_Valid, o_Ready, o_Quotient, o_Flags);
            end
        end
        i_Valid = 1'b0;
        handshake();
        n_tests++;
        if ({o_Valid, o_Ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL back_pressure_release: got vld=%b rdy=%b, expected vld=0 rdy=1", o_Valid, o_Ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
        int          spurious;
        i_Dividend = 32'h40C0_0000;
        i_Divisor  = 32'h4000_0000;
        i_Valid    = 1'b1;
        @(posedge i_CLK); #1;
        i_Valid = 1'b0;
        repeat (12) @(posedge i_CLK);
        #3 i_RSTn = 1'b0;
        #1;
        n_tests++;
        if ({o_Ready, o_Valid, o_Quotient, o_Flags} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got rdy=%b vld=%b q=%h f=%h, expected rdy=1 vld=0 q=0 f=0",
                     o_Ready, o_Valid, o_Quotient, o_Flags);
        end
        @(posedge i_CLK); @(posedge i_CLK); #1;
        i_RSTn = 1'b1;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge i_CLK); #1;
            if (o_Valid) spurious++;
        end
        n_tests++;
        if (spurious !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_spurious: got %0d valid cycles, expected 0", spurious);
        end
        do_op(32'h40C0_0000, 32'h4000_0000, q, f, lat);
        n_tests++;
        if (q !== 32'h4040_0000 || f !== 4'h0 || lat !== 26) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got q=%h f=%h lat=%0d, expected q=40400000 f=0 lat=26", q, f, lat);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, q, eq;
        logic [3:0]  f, ef;
        int          lat, el;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (o_Ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: got %b, expected 1", i, o_Ready);
            end
            a = rand_fp();
            b = rand_fp();
            ref_div(a, b, eq, ef, el);
            do_op(a, b, q, f, lat);
            n_tests++;
            if (q !== eq || f !== ef || lat !== el) begin
                n_fail++;
                $display("FAIL b2b_%0d: %h / %h got q=%h f=%h lat=%0d, expected q=%h f=%h lat=%0d",
                         i, a, b, q, f, lat, eq, ef, el);
            end
            handshake();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, eq;
        logic [3:0]  f, ef;
        int          lat, el;
        for (int i = 0; i < 200; i++) begin
            a = rand_fp();
            b = rand_fp();
            ref_div(a, b, eq, ef, el);
            do_op(a, b, q, f, lat);
            n_tests++;
            if (q !== eq || f !== ef || lat !== el) begin
                n_fail++;
                $display("FAIL random_%0d: %h / %h got q=%h f=%h lat=%0d, expected q=%h f=%h lat=%0d",
                         i, a, b, q, f, lat, eq, ef, el);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge i_CLK); #1;
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
